// File: rtl/aoc_pkg.sv
// Shared constants, UART receiver state encoding and the seven-segment glyph helper.
package aoc_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 25_000_000;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned ANSWER_W     = 32;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Hex nibble to active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_to_seg(logic [3:0] nib);
    logic [6:0] lit;
    lit = '0;
    case (nib)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      4'hF: lit = 7'b1000111;
      default: lit = '0;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: RX conditioning, falling-edge start detect and a framing FSM.
// Define AOC_RX_SYNC_EN to pass RX through a 2-flop synchronizer; otherwise a single
// register feeds the edge detector.
module uart_rx #(
  parameter int unsigned ClksPerBit = aoc_pkg::CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       busy_o,
  output logic       frame_err_o
);
  import aoc_pkg::*;

  localparam int unsigned CntW = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

  logic rx_sync_q;
  logic rx_prev_q;
  logic start_edge;

`ifdef AOC_RX_SYNC_EN
  logic rx_meta_q;
  // Two-flop synchronizer; resets low so a start needs a prior high sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end
`else
  // Single input register; resets low so a start needs a prior high sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 1'b0;
    end else begin
      rx_sync_q <= rx_i;
    end
  end
`endif

  // Previous conditioned sample for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_prev_q <= 1'b0;
    end else begin
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  uart_state_t     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic [7:0]      byte_data_q;
  logic            frame_err_q;

  // Frame FSM; strobes are registered and last exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_edge) state_q <= START;
        end
        START: begin
          if (cnt_q == CntHalf) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is already high again was a glitch.
            state_q   <= rx_sync_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CntFull) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/aoc_top.sv
// Board top: UART receiver feeding an on-the-fly max-group-sum parser, answer low byte
// on two seven-segment digits. RX conditioning depth is selected by AOC_RX_SYNC_EN.
module aoc_top #(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned ANSWER_W    = aoc_pkg::ANSWER_W
) (
  input  logic CLK,
  input  logic SW1,
  input  logic RX,
  output logic S1_A,
  output logic S1_B,
  output logic S1_C,
  output logic S1_D,
  output logic S1_E,
  output logic S1_F,
  output logic S1_G,
  output logic S2_A,
  output logic S2_B,
  output logic S2_C,
  output logic S2_D,
  output logic S2_E,
  output logic S2_F,
  output logic S2_G,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4
);
  import aoc_pkg::*;

  localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       busy;
  logic       frame_err;

  uart_rx #(
    .ClksPerBit(ClksPerBit)
  ) u_uart_rx (
    .clk_i       (CLK),
    .rst_ni      (SW1),
    .rx_i        (RX),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .busy_o      (busy),
    .frame_err_o (frame_err)
  );

  logic is_digit;
  logic is_lf;
  logic is_cr;

  assign is_digit = (byte_data >= ASCII_0) && (byte_data <= ASCII_9);
  assign is_lf    = (byte_data == ASCII_LF);
  assign is_cr    = (byte_data == ASCII_CR);

  logic led1_q;
  logic err_q;

  // Activity toggle per accepted byte and sticky error for framing or illegal bytes.
  always_ff @(posedge CLK or negedge SW1) begin
    if (!SW1) begin
      led1_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (byte_valid) led1_q <= ~led1_q;
      if (frame_err || (byte_valid && !is_digit && !is_lf && !is_cr)) err_q <= 1'b1;
    end
  end

  if (1) begin : sol
    logic [ANSWER_W-1:0] cur_q;
    logic [ANSWER_W-1:0] group_q;
    logic [ANSWER_W-1:0] best_q;
    logic [ANSWER_W-1:0] answer_q;
    logic                has_digit_q;
    logic [ANSWER_W-1:0] digit;
    logic [ANSWER_W-1:0] answer;

    assign digit  = ANSWER_W'(byte_data - ASCII_0);
    assign answer = answer_q;

    // Parser state moves on accepted bytes; answer tracks the open group every cycle.
    always_ff @(posedge CLK or negedge SW1) begin
      if (!SW1) begin
        cur_q       <= '0;
        group_q     <= '0;
        best_q      <= '0;
        answer_q    <= '0;
        has_digit_q <= 1'b0;
      end else begin
        if (byte_valid) begin
          if (is_digit) begin
            cur_q       <= cur_q * ANSWER_W'(10) + digit;
            has_digit_q <= 1'b1;
          end else if (is_lf) begin
            if (has_digit_q) begin
              group_q     <= group_q + cur_q;
              cur_q       <= '0;
              has_digit_q <= 1'b0;
            end else begin
              best_q  <= (group_q > best_q) ? group_q : best_q;
              group_q <= '0;
            end
          end
        end
        answer_q <= (best_q > group_q) ? best_q : group_q;
      end
    end
  end

  logic [6:0] seg_hi;
  logic [6:0] seg_lo;

  assign seg_hi = hex_to_seg(sol.answer[7:4]);
  assign seg_lo = hex_to_seg(sol.answer[3:0]);

  assign {S1_A, S1_B, S1_C, S1_D, S1_E, S1_F, S1_G} = seg_hi;
  assign {S2_A, S2_B, S2_C, S2_D, S2_E, S2_F, S2_G} = seg_lo;

  assign LED1 = led1_q;
  assign LED2 = busy;
  assign LED3 = err_q;
  assign LED4 = |sol.answer;

endmodule

// File: tb/tb_aoc_top.sv
// Directed bench for aoc_top: table of puzzle strings with expected answers, plus
// hand sequences for reset, framing error, glitch and reset mid-frame.
module tb_aoc_top;

  localparam int unsigned Baud = 115_200;
  localparam int unsigned Cpb  = 16;

  logic clk;
  logic sw1;
  logic rx;
  logic s1_a, s1_b, s1_c, s1_d, s1_e, s1_f, s1_g;
  logic s2_a, s2_b, s2_c, s2_d, s2_e, s2_f, s2_g;
  logic led1, led2, led3, led4;

  int n_checks = 0;
  int n_fail   = 0;

  aoc_top #(
    .CLK_FREQ_HZ(Baud * Cpb),
    .BAUD       (Baud),
    .ANSWER_W   (32)
  ) dut (
    .CLK (clk),
    .SW1 (sw1),
    .RX  (rx),
    .S1_A(s1_a), .S1_B(s1_b), .S1_C(s1_c), .S1_D(s1_d), .S1_E(s1_e), .S1_F(s1_f), .S1_G(s1_g),
    .S2_A(s2_a), .S2_B(s2_b), .S2_C(s2_c), .S2_D(s2_d), .S2_E(s2_e), .S2_F(s2_f), .S2_G(s2_g),
    .LED1(led1),
    .LED2(led2),
    .LED3(led3),
    .LED4(led4)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Active-low glyphs, a..g from MSB, for 0-9 A b C d E F.
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    string       text;
    logic [31:0] ans;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx  = 1'b1;
    sw1 = 1'b0;
    wait_cycles(3);
    sw1 = 1'b1;
    wait_cycles(5);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(Cpb);
    end
    rx = stop_bit;
    wait_cycles(Cpb);
    rx = 1'b1;
    if (!stop_bit) wait_cycles(Cpb);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    wait_cycles(10);
  endtask

  task automatic check_display(input string name, input logic [31:0] ans);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = ans[7:4];
    lo = ans[3:0];
    check({name, " answer"}, dut.sol.answer, ans);
    check({name, " S1"}, {25'd0, s1_a, s1_b, s1_c, s1_d, s1_e, s1_f, s1_g}, {25'd0, glyph[hi]});
    check({name, " S2"}, {25'd0, s2_a, s2_b, s2_c, s2_d, s2_e, s2_f, s2_g}, {25'd0, glyph[lo]});
    check({name, " LED4"}, {31'd0, led4}, {31'd0, (ans != 0)});
  endtask

  initial begin
    repeat (100_000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"1000\n2000\n3000\n\n4000\n\n5000\n6000\n\n7000\n8000\n9000\n\n10000\n",
                32'd24000, 1'b0};
    vecs[1] = '{"7\015\n9\015\n", 32'd16, 1'b0};
    vecs[2] = '{"99\n2\n\n50\n49\n", 32'd101, 1'b0};
    vecs[3] = '{"4294967295\n1\n", 32'd0, 1'b0};
    vecs[4] = '{"8\n77", 32'd8, 1'b0};
    vecs[5] = '{"300\n\n256\n", 32'd300, 1'b0};
    vecs[6] = '{"a\n3\n", 32'd3, 1'b1};

    rx  = 1'b1;
    sw1 = 1'b1;

    // Reset state.
    do_reset();
    check_display("reset", 32'd0);
    check("reset LED1", {31'd0, led1}, 32'd0);
    check("reset LED2", {31'd0, led2}, 32'd0);
    check("reset LED3", {31'd0, led3}, 32'd0);

    // Table-driven strings, each from a fresh reset.
    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      do_reset();
      send_str(vecs[v].text);
      check_display(nm, vecs[v].ans);
      check({nm, " LED3"}, {31'd0, led3}, {31'd0, vecs[v].err});
      check({nm, " LED1"}, {31'd0, led1}, {31'd0, vecs[v].text.len() % 2 == 1});
      check({nm, " LED2"}, {31'd0, led2}, 32'd0);
    end

    // Framing error: byte dropped, error sticky, later bytes still parsed.
    do_reset();
    send_byte(8'h31, 1'b0);
    check("ferr LED3", {31'd0, led3}, 32'd1);
    check("ferr LED1 dropped", {31'd0, led1}, 32'd0);
    send_byte(8'h35, 1'b1);
    check("ferr LED1 next", {31'd0, led1}, 32'd1);
    send_str("\n");
    check_display("ferr", 32'd5);
    check("ferr LED3 sticky", {31'd0, led3}, 32'd1);

    // Illegal character, then a short low glitch that must not produce a byte.
    do_reset();
    send_str("x");
    check("illegal LED3", {31'd0, led3}, 32'd1);
    check("illegal LED1", {31'd0, led1}, 32'd1);
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(2 * Cpb);
    check("glitch LED1", {31'd0, led1}, 32'd1);
    check("glitch LED2", {31'd0, led2}, 32'd0);
    send_str("3\n");
    check_display("glitch", 32'd3);
    check("glitch LED1 after", {31'd0, led1}, 32'd1);

    // Reset mid-frame during bit 4 of 0x0F; the partial byte must never appear.
    begin
      logic [7:0] b;
      b = 8'h0F;
      @(negedge clk);
      rx = 1'b0;
      wait_cycles(Cpb);
      for (int i = 0; i < 4; i++) begin
        rx = b[i];
        wait_cycles(Cpb);
      end
      rx = b[4];
      wait_cycles(Cpb / 2);
      check("midframe busy", {31'd0, led2}, 32'd1);
      sw1 = 1'b0;
      wait_cycles(2);
      check("midframe reset LED2", {31'd0, led2}, 32'd0);
      check("midframe reset answer", dut.sol.answer, 32'd0);
      sw1 = 1'b1;
      wait_cycles(Cpb / 2 - 2);
      for (int i = 5; i < 8; i++) begin
        rx = b[i];
        wait_cycles(Cpb);
      end
      rx = 1'b1;
      wait_cycles(Cpb);
      check("midframe no byte", {31'd0, led1}, 32'd0);
      send_str("42\n");
      check_display("midframe", 32'd42);
      check("midframe LED1", {31'd0, led1}, 32'd1);
      check("midframe LED3", {31'd0, led3}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
